// File: rtl/event_rr_dispatcher.sv
// Round-robin dispatcher: sticky per-source pending bits, rotating-priority
// winner search, and a registered valid/ready grant offer.
module event_rr_dispatcher #(
  parameter  int unsigned NUM_REQ = 8,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] flush_i,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [NUM_REQ-1:0] pending_o
);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] pending_q, pending_d, cand;
  logic [IDX_W-1:0]   ptr_q, gnt_idx_q, next_ptr, start, winner;
  logic               hs, found;
  int unsigned        j;

  always_comb begin
    hs       = (state_q == OFFER) && gnt_ready_i;
    next_ptr = (32'(gnt_idx_q) == NUM_REQ - 1) ? '0 : IDX_W'(32'(gnt_idx_q) + 1);
    start    = (state_q == OFFER) ? next_ptr : ptr_q;

    // While offering, the next winner excludes the current grant and any flushed bits.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand[i] = pending_q[i];
      if (state_q == OFFER && (i == 32'(gnt_idx_q) || flush_i[i])) cand[i] = 1'b0;
    end

    found  = 1'b0;
    winner = '0;
    j      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && cand[IDX_W'(j)]) begin
        found  = 1'b1;
        winner = IDX_W'(j);
      end
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_i[i])
        pending_d[i] = 1'b1;
      else if (hs && i == 32'(gnt_idx_q))
        pending_d[i] = 1'b0;
      else if (flush_i[i] && !(state_q == OFFER && i == 32'(gnt_idx_q)))
        pending_d[i] = 1'b0;
      else
        pending_d[i] = pending_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_idx_q <= winner;
            state_q   <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            ptr_q <= next_ptr;
            if (found) gnt_idx_q <= winner;
            else       state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign gnt_valid_o = (state_q == OFFER);
  assign gnt_idx_o   = gnt_idx_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_event_rr_dispatcher.sv
// Scoreboard bench for event_rr_dispatcher: an 8-source and a 5-source instance.
module tb_event_rr_dispatcher;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req, flush, pend;
  logic       ready, valid;
  logic [2:0] idx;
  logic [4:0] req5, flush5, pend5;
  logic       ready5, valid5;
  logic [2:0] idx5;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned q8[$];
  int unsigned q5[$];

  event_rr_dispatcher #(.NUM_REQ(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .flush_i(flush),
    .gnt_valid_o(valid), .gnt_ready_i(ready), .gnt_idx_o(idx), .pending_o(pend)
  );

  event_rr_dispatcher #(.NUM_REQ(5)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req5), .flush_i(flush5),
    .gnt_valid_o(valid5), .gnt_ready_i(ready5), .gnt_idx_o(idx5), .pending_o(pend5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain8(input int budget);
    int n = 0;
    while ((valid !== 1'b0 || pend !== 8'h00) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain8_idle", {31'd0, (valid === 1'b0 && pend === 8'h00)}, 32'd1);
  endtask

  // Handshakes complete at the next rising edge; sample them half a cycle early.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL grant8: unexpected grant idx %0d, none expected", idx);
      end else chk("grant8", {29'd0, idx}, q8.pop_front());
    end
    if (rst_n === 1'b1 && valid5 === 1'b1 && ready5 === 1'b1) begin
      if (q5.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL grant5: unexpected grant idx %0d, none expected", idx5);
      end else chk("grant5", {29'd0, idx5}, q5.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 8'hFF; flush = '0; ready = 1'b0;
    req5 = '0; flush5 = '0; ready5 = 1'b0;

    // Reset with requests asserted
    cyc(); cyc();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_idx", {29'd0, idx}, 32'd0);
    chk("rst_pend", {24'd0, pend}, 32'h00);
    chk("rst_valid5", {31'd0, valid5}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rel_pend", {24'd0, pend}, 32'hFF);
    chk("rel_valid", {31'd0, valid}, 32'd0);

    // Full-width round robin at one grant per cycle
    req = '0; ready = 1'b1;
    for (int i = 0; i < 8; i++) q8.push_back(i);
    for (int i = 0; i < 9; i++) cyc();
    chk("rr_done_valid", {31'd0, valid}, 32'd0);
    chk("rr_done_pend", {24'd0, pend}, 32'h00);

    // Single request latency
    q8.push_back(2);
    req = 8'h04; cyc();
    chk("single_pend", {24'd0, pend}, 32'h04);
    chk("single_valid_t1", {31'd0, valid}, 32'd0);
    req = '0; cyc();
    chk("single_valid_t2", {31'd0, valid}, 32'd1);
    chk("single_idx_t2", {29'd0, idx}, 32'd2);
    cyc();
    chk("single_pend_t3", {24'd0, pend}, 32'h00);
    chk("single_valid_t3", {31'd0, valid}, 32'd0);

    // Wrap: grant 5, then pending 0x41 -> 6, 0
    q8.push_back(5);
    req = 8'h20; cyc(); req = '0; cyc(); cyc();
    chk("wrap_idle", {31'd0, valid}, 32'd0);
    q8.push_back(6); q8.push_back(0);
    req = 8'h41; cyc(); req = '0; cyc();
    chk("wrap_idx6", {29'd0, idx}, 32'd6);
    cyc();
    chk("wrap_idx0", {29'd0, idx}, 32'd0);
    chk("wrap_pend", {24'd0, pend}, 32'h01);
    cyc();
    chk("wrap_end_valid", {31'd0, valid}, 32'd0);

    // Grant 7 so the pointer returns to 0
    q8.push_back(7);
    req = 8'h80; cyc(); req = '0;
    drain8(10);

    // Backpressure, then re-request of the bit being accepted
    ready = 1'b0;
    req = 8'h03; cyc(); req = '0; cyc();
    q8.push_back(0); q8.push_back(1); q8.push_back(0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_idx", {29'd0, idx}, 32'd0);
      cyc();
    end
    chk("stall_pend", {24'd0, pend}, 32'h03);
    ready = 1'b1; req = 8'h01; cyc();
    chk("rereq_pend", {24'd0, pend}, 32'h03);
    chk("rereq_idx", {29'd0, idx}, 32'd1);
    req = '0; cyc();
    chk("rereq_idx0", {29'd0, idx}, 32'd0);
    cyc();
    chk("rereq_end", {31'd0, valid}, 32'd0);

    // Flush of offered bit ignored, other bit cleared
    ready = 1'b0;
    req = 8'h30; cyc(); req = '0; cyc();
    chk("flush_idx", {29'd0, idx}, 32'd4);
    q8.push_back(4);
    flush = 8'h30; cyc(); flush = '0;
    chk("flush_pend", {24'd0, pend}, 32'h10);
    chk("flush_valid", {31'd0, valid}, 32'd1);
    cyc();
    ready = 1'b1; cyc();
    chk("flush_done_valid", {31'd0, valid}, 32'd0);
    chk("flush_done_pend", {24'd0, pend}, 32'h00);
    cyc(); cyc(); cyc();
    chk("flush_no5", {31'd0, valid}, 32'd0);

    // NUM_REQ=5 wrap from idx 4
    req5 = 5'h10; cyc(); req5 = '0; cyc();
    chk("n5_idx4", {29'd0, idx5}, 32'd4);
    req5 = 5'h09; cyc(); req5 = '0;
    q5.push_back(4); q5.push_back(0); q5.push_back(3);
    ready5 = 1'b1; cyc();
    chk("n5_idx0", {29'd0, idx5}, 32'd0);
    cyc();
    chk("n5_idx3", {29'd0, idx5}, 32'd3);
    cyc();
    chk("n5_valid_end", {31'd0, valid5}, 32'd0);
    chk("n5_pend_end", {27'd0, pend5}, 32'h00);

    // Mid-offer reset
    ready = 1'b0;
    req = 8'h0F; cyc(); req = '0; cyc();
    chk("mid_valid", {31'd0, valid}, 32'd1);
    chk("mid_idx", {29'd0, idx}, 32'd0);
    rst_n = 1'b0; cyc();
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_idx", {29'd0, idx}, 32'd0);
    chk("mid_rst_pend", {24'd0, pend}, 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    chk("post_rst_pend", {24'd0, pend}, 32'h00);

    chk("q8_empty", q8.size(), 32'd0);
    chk("q5_empty", q5.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/event_rr_dispatcher.md
Name: event_rr_dispatcher

Overview:
- Round-robin dispatcher for the event unit. Shares one downstream consumer among NUM_REQ event sources, for example the per-core dispatch/IRQ slot.
- Each source's request pulses are latched as sticky pending bits.
- A rotating-priority find-first-one search over the pending bits picks one winner. The winner's index is offered on a valid/ready handshake.
- Sustains one grant per cycle under continuous ready.

Parameters:
- NUM_REQ, 8, number of requesting sources (>=1).
- IDX_W, NUM_REQ>1 ? $clog2(NUM_REQ) : 1, localparam, grant index width (not overridable).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- req_i  input  NUM_REQ  request pulses; each set bit sets the corresponding pending bit.
- flush_i  input  NUM_REQ  clears the corresponding pending bits.
- gnt_valid_o  input/output: output  1  grant offer valid.
- gnt_ready_i  input  1  consumer accepts the offer.
- gnt_idx_o  output  IDX_W  index of the granted source.
- pending_o  output  NUM_REQ  current pending_q register.

Behaviour:
- Registers:
  - pending_q[NUM_REQ]
  - ptr_q[IDX_W]: search start index
  - gnt_idx_q
  - state_q in {IDLE, OFFER}
- Reset (rst_ni=0 at a rising edge, including mid-offer): pending_q=0, ptr_q=0, gnt_idx_q=0, state_q=IDLE. Consequently gnt_valid_o=0, gnt_idx_o=0, pending_o=0 from the next cycle.
- gnt_valid_o = (state_q==OFFER); gnt_idx_o = gnt_idx_q. Both are driven from registers only, with no combinational path from inputs.
- Handshake: hs = gnt_valid_o & gnt_ready_i. While gnt_valid_o=1 and no hs, gnt_idx_o and gnt_valid_o are held stable. A valid is never withdrawn.
- Winner search:
  - Runs over the candidate vector cand.
  - Finds the first set bit at index >= ptr_q. If none exists, finds the first set bit from index 0 (wrap).
  - Implemented as a double-width or masked find-first-one; result is in range 0..NUM_REQ-1.
- Pending update, per bit i, in priority order:
  1. req_i[i]=1 -> bit set. New events are never lost, even if the same bit is being cleared by hs or flush.
  2. Else, hs and i==gnt_idx_q -> bit cleared.
  3. Else, flush_i[i]=1 and not (state_q==OFFER and i==gnt_idx_q) -> bit cleared. Flush of the bit being offered is ignored; the offer completes normally.
  4. Else, bit holds.
- IDLE:
  - cand = pending_q.
  - If cand!=0: gnt_idx_q <= winner, state -> OFFER.
  - req_i is not in cand, so latency is req_i at edge t -> pending_q at t+1 -> gnt_valid_o at t+2.
- OFFER:
  - No hs: hold.
  - On hs:
    - ptr_q <= (gnt_idx_q==NUM_REQ-1) ? 0 : gnt_idx_q+1. Wrap is explicit, which covers NUM_REQ that are not powers of two.
    - cand = pending_q with bit gnt_idx_q masked and with flush_i bits masked. Same-cycle req_i is not included.
    - If cand!=0: gnt_idx_q <= winner computed with the new start (gnt_idx_q+1 wrapped); stay in OFFER, giving back-to-back grants.
    - Else: go to IDLE.
- ptr_q changes only on hs.
- NUM_REQ=1: gnt_idx_o is always 0; the block degenerates to a pending flag plus handshake.
- No X on outputs after reset. gnt_idx_o < NUM_REQ at all times.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with req_i=0xFF -> gnt_valid_o=0, gnt_idx_o=0, pending_o=0x00. After release, pending_o=0xFF one cycle after the first req_i sample.
- Single request, NUM_REQ=8:
  - Stimulus: req_i=0x04 at cycle t, gnt_ready_i=1.
  - Response: pending_o=0x04 at t+1; gnt_valid_o=1 with idx=2 at t+2; pending_o=0x00 and gnt_valid_o=0 at t+3; internal ptr=3.
- Round-robin throughput:
  - Stimulus: a single pulse req_i=0xFF, gnt_ready_i held at 1.
  - Response: idx sequence 0,1,2,3,4,5,6,7 on 8 consecutive cycles, then gnt_valid_o=0.
- Wrap:
  - Stimulus: after granting idx 5, load pending 0x41.
  - Response: grant 6, then grant 0.
- Wrap, NUM_REQ=5: after granting idx 4 with pending 0x09 -> grant 0, then grant 3.
- Backpressure and re-request:
  - Stimulus: pending 0x03 with idx 0 offered; gnt_ready_i=0 for 5 cycles; then assert gnt_ready_i together with req_i=0x01 in the same cycle.
  - Response: idx stays 0 and valid stays 1 during stall; pending_o stays 0x03 after hs; grant order is 0, 1, 0.
- Flush:
  - Stimulus: pending 0x30 with idx 4 offered; flush_i=0x30 for one cycle; gnt_ready_i=1 two cycles later.
  - Response: pending_o=0x10 after flush; idx 4 completes; gnt_valid_o drops; 5 is never granted.
- Mid-offer reset: while offering with pending 0x0F, assert rst_ni=0 for one cycle -> all outputs 0 next cycle; after release with no req_i, no grant is issued.
